// File: rtl/u712_chip_cycle_request.sv
// 68040-side chip RAM / custom-register cycle initiator: splits CPU accesses into Agnus word cycles.
// Optional slot-wait watchdog enabled by defining CHIP_TIMEOUT_EN.
module u712_chip_cycle_request #(
    parameter int RECOVER_CLKS = 3,
    parameter int TIMEOUT_CLKS = 255
) (
    input  logic        CLK40,
    input  logic        RESETn,
    input  logic        TSn,
    input  logic [31:0] A,
    input  logic        RnW,
    input  logic [1:0]  SIZ,
    input  logic [31:0] D_IN,
    input  logic        SLOT_GRANT,
    input  logic        SLOT_DONE,
    input  logic [15:0] CHIP_DIN,
    output logic        CHIP_REQ,
    output logic        CHIP_RnW,
    output logic        CHIP_REG,
    output logic [19:0] CHIP_ADDR,
    output logic        CHIP_UDSn,
    output logic        CHIP_LDSn,
    output logic [15:0] CHIP_DOUT,
    output logic [31:0] CPU_RDATA,
    output logic        AGNUS_TACK,
    output logic        CYCLE_ERR
);

    typedef enum logic [2:0] {IDLE, REQ, WAIT, ACK, RECOVER} state_t;

    localparam logic [7:0] REC_LAST = 8'(RECOVER_CLKS - 1);

    if (RECOVER_CLKS < 1 || RECOVER_CLKS > 256) begin : g_bad_recover
        $error("RECOVER_CLKS must be 1..256");
    end

    state_t      state_q, state_d;
    logic        req_q, req_d;
    logic        rnw_q, rnw_d;
    logic        reg_q, reg_d;
    logic [19:0] addr_q, addr_d;
    logic        udsn_q, udsn_d;
    logic        ldsn_q, ldsn_d;
    logic [15:0] dout_q, dout_d;
    logic [31:0] rdata_q, rdata_d;
    logic        tack_q, tack_d;
    logic        err_q, err_d;
    logic        hi_q, hi_d;
    logic        pend_q, pend_d;
    logic [15:0] lo_q, lo_d;
    logic [7:0]  rec_q, rec_d;

    logic        is_reg;
    logic        hit;
    logic [19:0] base;
    logic        grant_now;
    logic        done_now;

`ifdef CHIP_TIMEOUT_EN
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CLKS - 1);

    if (TIMEOUT_CLKS < 1 || TIMEOUT_CLKS > 256) begin : g_bad_timeout
        $error("TIMEOUT_CLKS must fit the 8-bit watchdog");
    end

    logic [7:0] tmo_q, tmo_d;
`endif

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        rnw_d   = rnw_q;
        reg_d   = reg_q;
        addr_d  = addr_q;
        udsn_d  = udsn_q;
        ldsn_d  = ldsn_q;
        dout_d  = dout_q;
        rdata_d = rdata_q;
        tack_d  = 1'b0;
        err_d   = 1'b0;
        hi_d    = hi_q;
        pend_d  = pend_q;
        lo_d    = lo_q;
        rec_d   = rec_q;

        is_reg = (A[31:12] == 20'h00DFF);
        hit    = (A[31:21] == 11'd0) || is_reg;
        // Register space is addressed by its offset within the 1 MB window; CHIP_REG tells it apart.
        base   = is_reg ? {1'b0, A[19:1]} : A[20:1];

        grant_now = (state_q == REQ) && SLOT_GRANT;
        done_now  = ((state_q == REQ) && SLOT_GRANT && SLOT_DONE) ||
                    ((state_q == WAIT) && SLOT_DONE);

        case (state_q)
            IDLE: begin
                if (!TSn && hit) begin
                    state_d = REQ;
                    req_d   = 1'b1;
                    rnw_d   = RnW;
                    reg_d   = is_reg;
                    lo_d    = D_IN[15:0];
                    case (SIZ)
                        2'b01: begin
                            addr_d = base;
                            udsn_d = A[0];
                            ldsn_d = ~A[0];
                            dout_d = A[1] ? D_IN[15:0] : D_IN[31:16];
                            hi_d   = ~A[1];
                            pend_d = 1'b0;
                        end
                        2'b10: begin
                            addr_d = base;
                            udsn_d = 1'b0;
                            ldsn_d = 1'b0;
                            dout_d = A[1] ? D_IN[15:0] : D_IN[31:16];
                            hi_d   = ~A[1];
                            pend_d = 1'b0;
                        end
                        default: begin
                            // Long and line: high word first, low word queued behind it.
                            addr_d = {base[19:1], 1'b0};
                            udsn_d = 1'b0;
                            ldsn_d = 1'b0;
                            dout_d = D_IN[31:16];
                            hi_d   = 1'b1;
                            pend_d = 1'b1;
                        end
                    endcase
                end
            end
            REQ: begin
                if (grant_now) begin
                    req_d   = 1'b0;
                    state_d = WAIT;
                end
            end
            WAIT: begin
            end
            ACK: begin
                state_d = RECOVER;
                rec_d   = 8'd0;
            end
            RECOVER: begin
                if (rec_q == REC_LAST) begin
                    state_d = IDLE;
                end else begin
                    rec_d = rec_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (done_now) begin
            if (rnw_q) begin
                if (hi_q) begin
                    rdata_d[31:16] = CHIP_DIN;
                end else begin
                    rdata_d[15:0] = CHIP_DIN;
                end
            end
            if (pend_q) begin
                pend_d  = 1'b0;
                addr_d  = {addr_q[19:1], 1'b1};
                dout_d  = lo_q;
                hi_d    = 1'b0;
                req_d   = 1'b1;
                state_d = REQ;
            end else begin
                req_d   = 1'b0;
                tack_d  = 1'b1;
                state_d = ACK;
            end
        end

`ifdef CHIP_TIMEOUT_EN
        tmo_d = 8'd0;
        if ((state_q == REQ) || (state_q == WAIT)) begin
            if (grant_now || done_now) begin
                tmo_d = 8'd0;
            end else if (tmo_q == TMO_LAST) begin
                // Abort: terminate the CPU access with all-ones data and flag the error.
                req_d   = 1'b0;
                pend_d  = 1'b0;
                tack_d  = 1'b1;
                err_d   = 1'b1;
                rdata_d = 32'hFFFF_FFFF;
                state_d = ACK;
            end else begin
                tmo_d = tmo_q + 8'd1;
            end
        end
`endif
    end

    always_ff @(posedge CLK40) begin
        if (!RESETn) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            rnw_q   <= 1'b1;
            reg_q   <= 1'b0;
            addr_q  <= 20'd0;
            udsn_q  <= 1'b1;
            ldsn_q  <= 1'b1;
            dout_q  <= 16'd0;
            rdata_q <= 32'd0;
            tack_q  <= 1'b0;
            err_q   <= 1'b0;
            hi_q    <= 1'b1;
            pend_q  <= 1'b0;
            lo_q    <= 16'd0;
            rec_q   <= 8'd0;
`ifdef CHIP_TIMEOUT_EN
            tmo_q   <= 8'd0;
`endif
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            rnw_q   <= rnw_d;
            reg_q   <= reg_d;
            addr_q  <= addr_d;
            udsn_q  <= udsn_d;
            ldsn_q  <= ldsn_d;
            dout_q  <= dout_d;
            rdata_q <= rdata_d;
            tack_q  <= tack_d;
            err_q   <= err_d;
            hi_q    <= hi_d;
            pend_q  <= pend_d;
            lo_q    <= lo_d;
            rec_q   <= rec_d;
`ifdef CHIP_TIMEOUT_EN
            tmo_q   <= tmo_d;
`endif
        end
    end

    assign CHIP_REQ   = req_q;
    assign CHIP_RnW   = rnw_q;
    assign CHIP_REG   = reg_q;
    assign CHIP_ADDR  = addr_q;
    assign CHIP_UDSn  = udsn_q;
    assign CHIP_LDSn  = ldsn_q;
    assign CHIP_DOUT  = dout_q;
    assign CPU_RDATA  = rdata_q;
    assign AGNUS_TACK = tack_q;
    assign CYCLE_ERR  = err_q;

endmodule
